udma_eth_rx_filter: RTL

Destination-address filter and frame-length guard on the receive path, in the 125 MHz Ethernet clock domain, between the MAC's AXI-stream byte output and the rx controller's size monitor / rx data buffer. It holds each frame's first six bytes, decides whether to forward or discard the frame, and then passes it through byte by byte. It also truncates over-length frames and reports drops and errors. Downstream therefore sees only accepted, length-bounded frames, and every forwarded frame ends in exactly one tlast.

---
 rtl/udma_eth_pkg.sv | 16 +
 rtl/udma_eth_mac_match.sv | 27 ++
 rtl/udma_eth_rx_filter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/udma_eth_pkg.sv
// rtl/udma_eth_pkg.sv - shared types and constants for the udma ethernet rx path
package udma_eth_pkg;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_DECIDE,
    ST_REPLAY,
    ST_PASS,
    ST_DISCARD
  } rx_filt_state_e;

  localparam int          HDR_LEN        = 6;
  localparam int          LEN_WIDTH      = 11;
  localparam logic [47:0] ETH_BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/udma_eth_mac_match.sv
// rtl/udma_eth_mac_match.sv - destination address acceptance comparator
// Group-address acceptance is built in when UDMA_ETH_RX_MCAST_EN is defined.
module udma_eth_mac_match
  import udma_eth_pkg::*;
(
  input  logic [47:0] hdr,
  input  logic [47:0] mac_addr,
  input  logic        promisc,
  input  logic        bcast_en,
  output logic        accept
);

  logic mcast_hit;

`ifdef UDMA_ETH_RX_MCAST_EN
  // I/G bit is bit 0 of the first byte on the wire
  assign mcast_hit = hdr[40];
`else
  assign mcast_hit = 1'b0;
`endif

  assign accept = promisc
                | (hdr == mac_addr)
                | (bcast_en & (hdr == ETH_BCAST_ADDR))
                | mcast_hit;

endmodule

// File: rtl/udma_eth_rx_filter.sv
// rtl/udma_eth_rx_filter.sv - rx destination filter and frame length guard
// Multicast acceptance is enabled by defining UDMA_ETH_RX_MCAST_EN.
module udma_eth_rx_filter #(
  parameter int MAX_FRAME_LEN = 1518,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 eth_clk_i,
  input  logic                 eth_rstn_i,
  input  logic [47:0]          cfg_mac_addr_i,
  input  logic                 cfg_promisc_i,
  input  logic                 cfg_bcast_en_i,
  input  logic                 cfg_drop_cnt_clr_i,
  input  logic [7:0]           s_axis_tdata_i,
  input  logic                 s_axis_tvalid_i,
  input  logic                 s_axis_tlast_i,
  input  logic                 s_axis_tuser_i,
  output logic                 s_axis_tready_o,
  output logic [7:0]           m_axis_tdata_o,
  output logic                 m_axis_tvalid_o,
  output logic                 m_axis_tlast_o,
  output logic                 m_axis_tuser_o,
  input  logic                 m_axis_tready_i,
  output logic                 drop_event_o,
  output logic                 err_event_o,
  output logic [CNT_WIDTH-1:0] drop_count_o
);
  import udma_eth_pkg::*;

  localparam logic [LEN_WIDTH-1:0] MAX_LEN  = LEN_WIDTH'(MAX_FRAME_LEN);
  localparam logic [2:0]           LAST_IDX = 3'(HDR_LEN - 1);

  rx_filt_state_e       state;
  logic [7:0]           hdr [HDR_LEN];
  logic [2:0]           idx;
  logic [2:0]           rep_idx;
  logic [LEN_WIDTH-1:0] len;
  logic                 last6;
  logic [47:0]          hdr_flat;
  logic                 accept;
  logic                 s_xfer;
  logic                 m_xfer;
  logic                 trunc;
  logic                 drop_now;

  assign hdr_flat = {hdr[0], hdr[1], hdr[2], hdr[3], hdr[4], hdr[5]};

  udma_eth_mac_match u_match (
    .hdr      (hdr_flat),
    .mac_addr (cfg_mac_addr_i),
    .promisc  (cfg_promisc_i),
    .bcast_en (cfg_bcast_en_i),
    .accept   (accept)
  );

  assign s_xfer = s_axis_tvalid_i & s_axis_tready_o;
  assign m_xfer = m_axis_tvalid_o & m_axis_tready_i;

  // The byte that brings the count to the limit closes the frame early
  assign trunc = (state == ST_PASS) & ~s_axis_tlast_i
               & ((len + LEN_WIDTH'(1)) == MAX_LEN);

  assign drop_now = ((state == ST_HDR) & s_xfer & s_axis_tlast_i & (idx != LAST_IDX))
                  | ((state == ST_DECIDE) & ~accept);

  always_comb begin
    s_axis_tready_o = 1'b0;
    m_axis_tvalid_o = 1'b0;
    m_axis_tdata_o  = 8'h00;
    m_axis_tlast_o  = 1'b0;
    m_axis_tuser_o  = 1'b0;
    case (state)
      ST_HDR:     s_axis_tready_o = 1'b1;
      ST_REPLAY: begin
        m_axis_tvalid_o = 1'b1;
        m_axis_tdata_o  = hdr[rep_idx];
        m_axis_tlast_o  = last6 & (rep_idx == LAST_IDX);
      end
      ST_PASS: begin
        s_axis_tready_o = m_axis_tready_i;
        m_axis_tvalid_o = s_axis_tvalid_i;
        m_axis_tdata_o  = s_axis_tdata_i;
        m_axis_tlast_o  = s_axis_tlast_i | trunc;
        m_axis_tuser_o  = s_axis_tuser_i | trunc;
      end
      ST_DISCARD: s_axis_tready_o = 1'b1;
      default:    s_axis_tready_o = 1'b0;
    endcase
  end

  always_ff @(posedge eth_clk_i or negedge eth_rstn_i) begin
    if (!eth_rstn_i) begin
      state        <= ST_HDR;
      idx          <= '0;
      rep_idx      <= '0;
      len          <= '0;
      last6        <= 1'b0;
      drop_event_o <= 1'b0;
      err_event_o  <= 1'b0;
      drop_count_o <= '0;
      for (int i = 0; i < HDR_LEN; i++) hdr[i] <= 8'h00;
    end else begin
      drop_event_o <= drop_now;
      err_event_o  <= 1'b0;

      if (cfg_drop_cnt_clr_i)
        drop_count_o <= '0;
      else if (drop_now && (drop_count_o != {CNT_WIDTH{1'b1}}))
        drop_count_o <= drop_count_o + 1'b1;

      case (state)
        ST_HDR: begin
          if (s_xfer) begin
            hdr[idx] <= s_axis_tdata_i;
            if (idx == LAST_IDX) begin
              idx   <= '0;
              last6 <= s_axis_tlast_i;
              state <= ST_DECIDE;
            end else if (s_axis_tlast_i) begin
              idx <= '0;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        ST_DECIDE: begin
          rep_idx <= '0;
          if (accept)     state <= ST_REPLAY;
          else if (last6) state <= ST_HDR;
          else            state <= ST_DISCARD;
        end
        ST_REPLAY: begin
          if (m_xfer) begin
            if (rep_idx == LAST_IDX) begin
              rep_idx <= '0;
              len     <= LEN_WIDTH'(HDR_LEN);
              state   <= last6 ? ST_HDR : ST_PASS;
            end else begin
              rep_idx <= rep_idx + 3'd1;
            end
          end
        end
        ST_PASS: begin
          if (s_xfer) begin
            len <= len + LEN_WIDTH'(1);
            if (s_axis_tlast_i) begin
              err_event_o <= s_axis_tuser_i;
              state       <= ST_HDR;
            end else if (trunc) begin
              err_event_o <= 1'b1;
              state       <= ST_DISCARD;
            end
          end
        end
        ST_DISCARD: begin
          if (s_xfer && s_axis_tlast_i) state <= ST_HDR;
        end
        default: state <= ST_HDR;
      endcase
    end
  end

endmodule
